// File: rtl/chaos_image_decryptor.sv
// rtl/chaos_image_decryptor.sv - in-place inverse of the x/y/z chaotic image cipher
// Undoes z-confusion (descending swaps), y-diffusion (XOR), then x-confusion.
module chaos_image_decryptor #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        key_sel,
  output logic [ADDR_W-1:0] key_addr,
  input  logic [DATA_W-1:0] key_rdata,
  output logic [ADDR_W-1:0] img_addr,
  output logic              img_we,
  output logic [DATA_W-1:0] img_wdata,
  input  logic [DATA_W-1:0] img_rdata
);

  typedef enum logic [3:0] {
    IDLE, C_KEY, C_IDX, C_RDK, C_RDJ, C_WRK, C_WRJ, D_RD, D_LAT, D_WR, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] K_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] j;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] t;
  // 0 while undoing the z pass, 1 while undoing the x pass
  logic              stage_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      j       <= '0;
      a       <= '0;
      b       <= '0;
      t       <= '0;
      stage_x <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k       <= K_MAX;
            stage_x <= 1'b0;
            state   <= C_KEY;
          end
        end
        C_KEY: state <= C_IDX;
        C_IDX: begin
          j     <= key_rdata[ADDR_W-1:0];
          state <= C_RDK;
        end
        C_RDK: begin
          a     <= img_rdata;
          state <= C_RDJ;
        end
        C_RDJ: begin
          b     <= img_rdata;
          state <= C_WRK;
        end
        C_WRK: state <= C_WRJ;
        C_WRJ: begin
          if (k != '0) begin
            k     <= k - 1'b1;
            state <= C_KEY;
          end else if (!stage_x) begin
            k     <= '0;
            state <= D_RD;
          end else begin
            state <= DONE;
          end
        end
        D_RD:  state <= D_LAT;
        D_LAT: begin
          t     <= img_rdata ^ key_rdata;
          state <= D_WR;
        end
        D_WR: begin
          if (k == K_MAX) begin
            k       <= K_MAX;
            stage_x <= 1'b1;
            state   <= C_KEY;
          end else begin
            k     <= k + 1'b1;
            state <= D_RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are a pure decode of state and the index registers
  always_comb begin
    key_sel   = 2'd0;
    key_addr  = '0;
    img_addr  = '0;
    img_we    = 1'b0;
    img_wdata = '0;
    case (state)
      C_KEY: begin
        key_sel  = stage_x ? 2'd0 : 2'd2;
        key_addr = k;
      end
      C_IDX: img_addr = k;
      C_RDK: img_addr = j;
      C_WRK: begin
        img_addr  = k;
        img_we    = 1'b1;
        img_wdata = b;
      end
      C_WRJ: begin
        img_addr  = j;
        img_we    = 1'b1;
        img_wdata = a;
      end
      D_RD: begin
        key_sel  = 2'd1;
        key_addr = k;
        img_addr = k;
      end
      D_WR: begin
        img_addr  = k;
        img_we    = 1'b1;
        img_wdata = t;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule
